bcd_digit_counter: RTL

//   Two-digit BCD up/down counter with a programmable tick prescaler.

---
 rtl/bcd_digit_counter_if.sv | 28 ++
 rtl/bcd_digit_counter.sv | 98 +++++++++
 2 files changed

// File: rtl/bcd_digit_counter_if.sv
// Control and digit bus of the two-digit BCD counter.
// Latency: n/a (wires only).
// Backpressure: none; the counter has no stall path.
interface bcd_digit_counter_if;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens;
    logic       d;
    logic       c;
    logic       b;
    logic       a;
    logic       carry;
    logic       load_err;

    modport master (
        output en, up_dn, clr, load, load_tens, load_ones,
        input  tens, d, c, b, a, carry, load_err
    );

    modport slave (
        input  en, up_dn, clr, load, load_tens, load_ones,
        output tens, d, c, b, a, carry, load_err
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD up/down counter, one step every DIV enabled clocks; ones digit feeds the code converter.
// Latency: digits, carry and load_err are registered and appear 1 clk after the tick/load/clr cycle.
// Backpressure: none; en=0 freezes prescaler and digits, clr > load > tick > hold.
module bcd_digit_counter #(
    parameter int DIV   = 10,
    parameter int DIV_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_digit_counter_if.slave   bus
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       tens_q,  tens_d;
    logic [3:0]       ones_q,  ones_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;
    logic             tick;
    logic             tens_bad;
    logic             ones_bad;

    assign tick     = bus.en && (presc_q == PRESC_LAST);
    assign tens_bad = (bus.load_tens > 4'd9);
    assign ones_bad = (bus.load_ones > 4'd9);

    always_comb begin
        presc_d    = presc_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;

        if (bus.clr) begin
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (bus.load) begin
            // Out-of-range nibbles load as 0 so digits never leave 0..9.
            presc_d    = '0;
            tens_d     = tens_bad ? 4'd0 : bus.load_tens;
            ones_d     = ones_bad ? 4'd0 : bus.load_ones;
            load_err_d = tens_bad || ones_bad;
        end else if (tick) begin
            presc_d = '0;
            if (bus.up_dn) begin
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    if (tens_q == 4'd9) begin
                        tens_d  = 4'd0;
                        carry_d = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    if (tens_q == 4'd0) begin
                        tens_d  = 4'd9;
                        carry_d = 1'b1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end else if (bus.en) begin
            presc_d = presc_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.tens                     = tens_q;
    assign {bus.d, bus.c, bus.b, bus.a} = ones_q;
    assign bus.carry                    = carry_q;
    assign bus.load_err                 = load_err_q;

endmodule
